// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues word-addressed fetches,
// holds the fetched word for decode and selects the next PC at retire.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        zero,
    input  logic        BranchBeq,
    input  logic        BranchJal,
    input  logic        BranchJalr,
    input  logic [31:0] ALUOut,
    input  logic [31:0] ExtOp,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PC_4,
    output logic        fetch_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] VALID = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [7:0]  wait_cnt;
    logic [31:0] pc_next;
    logic        retire;

    assign imem_addr = PC;
    assign PC_4      = PC + 32'd1;
    assign retire    = (state == VALID) && !stall;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  state_n = REQ;
            REQ: begin
                if (imem_ack)
                    state_n = VALID;
                else if (wait_cnt == WAIT_LAST)
                    state_n = ERROR;
            end
            VALID: begin
                if (!stall)
                    state_n = REQ;
            end
            ERROR: state_n = ERROR;
        endcase
    end

    // Jalr outranks Jal/Beq when several are asserted together
    always_comb begin
        pc_next = PC_4;
        if (BranchJalr)
            pc_next = ALUOut;
        else if ((BranchBeq && zero) || BranchJal)
            pc_next = ExtOp;
    end

    // Outputs are registered from the next state so they track it exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            PC          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= 8'h0;
        end else begin
            state       <= state_n;
            imem_req    <= (state_n == REQ);
            instr_valid <= (state_n == VALID);
            fetch_err   <= (state_n == ERROR);
            if (state == REQ && imem_ack)
                instr <= imem_rdata;
            if (retire)
                PC <= pc_next;
            if (state != REQ)
                wait_cnt <= 8'h0;
            else if (!imem_ack)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: fetched {PC, word} pairs are
// queued at ack time and compared when instr_valid appears.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        zero;
    logic        BranchBeq;
    logic        BranchJal;
    logic        BranchJalr;
    logic [31:0] ALUOut;
    logic [31:0] ExtOp;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PC_4;
    logic        fetch_err;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_pc;
    logic [63:0] sb[$];

    fetch_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .zero       (zero),
        .BranchBeq  (BranchBeq),
        .BranchJal  (BranchJal),
        .BranchJalr (BranchJalr),
        .ALUOut     (ALUOut),
        .ExtOp      (ExtOp),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .PC         (PC),
        .PC_4       (PC_4),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_next(
        input logic [31:0] pc, input logic jalr, input logic jal,
        input logic beq, input logic z,
        input logic [31:0] alu, input logic [31:0] ext);
        if (jalr) return alu;
        if ((beq && z) || jal) return ext;
        return pc + 32'd1;
    endfunction

    task automatic clear_branch();
        BranchJalr = 1'b0;
        BranchJal  = 1'b0;
        BranchBeq  = 1'b0;
        zero       = 1'b0;
        ALUOut     = 32'h0;
        ExtOp      = 32'h0;
    endtask

    task automatic do_fetch(
        input logic [31:0] rdata, input int ack_delay, input int stall_cyc,
        input logic jalr, input logic jal, input logic beq, input logic z,
        input logic [31:0] alu, input logic [31:0] ext);
        int          n;
        logic [63:0] e;
        logic [31:0] nxt;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'b0, imem_req}, 32'd1);
        check("imem_addr", imem_addr, exp_pc);
        repeat (ack_delay) @(negedge clk);
        check("req_held", {31'b0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        sb.push_back({exp_pc, rdata});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = ~rdata;
        check("instr_valid", {31'b0, instr_valid}, 32'd1);
        check("req_in_valid", {31'b0, imem_req}, 32'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("instr", instr, e[31:0]);
            check("pc", PC, e[63:32]);
        end
        check("pc_4", PC_4, exp_pc + 32'd1);
        // Stalled cycles: late acks and branch inputs must be ignored
        for (int k = 0; k < stall_cyc; k++) begin
            stall      = 1'b1;
            imem_ack   = 1'b1;
            BranchJalr = 1'b1;
            ALUOut     = 32'hDEAD_0000;
            @(negedge clk);
            check("stall_instr", instr, rdata);
            check("stall_pc", PC, exp_pc);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        imem_ack   = 1'b0;
        stall      = 1'b0;
        BranchJalr = jalr;
        BranchJal  = jal;
        BranchBeq  = beq;
        zero       = z;
        ALUOut     = alu;
        ExtOp      = ext;
        nxt = model_next(exp_pc, jalr, jal, beq, z, alu, ext);
        @(negedge clk);
        clear_branch();
        check("retire_valid", {31'b0, instr_valid}, 32'd0);
        check("retire_req", {31'b0, imem_req}, 32'd1);
        check("next_pc", PC, nxt);
        exp_pc = nxt;
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        stall      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        clear_branch();
        exp_pc = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_pc", PC, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_to_req", {31'b0, imem_req}, 32'd1);

        // Back-to-back sequential fetches 0,1,2,3,4
        for (int i = 0; i < 5; i++)
            do_fetch(32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0);
        // PC=5: stall three cycles, then taken Beq
        do_fetch(32'hA5A5_0005, 0, 3, 0, 0, 1, 1, 32'h0, 32'h40);
        // Jalr outranks Jal
        do_fetch(32'h0000_0040, 0, 0, 1, 1, 0, 0, 32'h80, 32'h40);
        // Beq not taken with zero=0
        do_fetch(32'h0000_0080, 0, 0, 0, 0, 1, 0, 32'h0, 32'h40);
        // Jal to the last word, then wrap to 0
        do_fetch(32'h0000_0081, 0, 0, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFFF);
        do_fetch(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_addr", imem_addr, 32'h0);
        // Ack on the last cycle before timeout is still accepted
        do_fetch(32'h0BAD_CAFE, 14, 0, 0, 0, 0, 0, 0, 0);

        // Timeout at PC=1
        n = 0;
        while (imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_cycles", n, 32'd15);
        check("err_set", {31'b0, fetch_err}, 32'd1);
        check("err_req", {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        check("err_sticky", {31'b0, fetch_err}, 32'd1);
        check("err_valid", {31'b0, instr_valid}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("err_rst", {31'b0, fetch_err}, 32'd0);
        check("err_rst_pc", PC, 32'h0);
        @(negedge clk);
        reset  = 1'b0;
        exp_pc = 32'h0;

        // Abort a fetch in REQ with an asynchronous reset
        do_fetch(32'h1111_1111, 0, 0, 0, 1, 0, 0, 32'h0, 32'h40);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_2222;
        #2 reset = 1'b1;
        #1;
        check("abort_req", {31'b0, imem_req}, 32'd0);
        check("abort_pc", PC, 32'h0);
        check("abort_instr", instr, 32'h0);
        check("abort_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        check("abort_held", {31'b0, instr_valid}, 32'd0);
        reset  = 1'b0;
        exp_pc = 32'h0;
        do_fetch(32'h3333_3333, 0, 0, 0, 0, 0, 0, 0, 0);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
